// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button debounce, RUN/HALT/ADJ sequencing and timing strobes for the min/sec counter
module stopwatch_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int DW = $clog2(DB_CYCLES);
  logic [1:0] sync;
  logic level, level_q;
  logic [DW-1:0] cnt;
  // synchronize, then accept a new level only after it has been stable for DB_CYCLES
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      level_q <= level;
      if (sync[1] != level) begin
        if (cnt == DW'(DB_CYCLES - 1)) begin
          level <= sync[1];
          cnt <= '0;
        end else
          cnt <= cnt + 1'b1;
      end else
        cnt <= '0;
    end
  assign press = level & ~level_q;
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 100000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       clr,
  output logic       paused,
  output logic [1:0] mode,
  output logic       blank_min,
  output logic       blank_sec,
  output logic [1:0] scan_idx
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ADJ_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, ADJ = 2'd2} state_t;
  state_t state, state_n;
  logic pause_press, clr_press, paused_n;
  logic [1:0] adj_sync, sel_sync;
  logic adj_s, sel_s;
  logic [TW-1:0] run_cnt;
  logic [AW-1:0] adj_cnt;
  logic [BW-1:0] blink_cnt;
  logic [SW-1:0] scan_cnt;
  logic blink_phase;
  logic run_tick, adj_tick, adj_stay, adj_exit, blink_end, scan_end;

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause (.clk(clk), .rst(rst), .raw(btn_pause), .press(pause_press));
  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (.clk(clk), .rst(rst), .raw(btn_clr), .press(clr_press));

  // switches only need synchronizing, no debounce
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      adj_sync <= '0;
      sel_sync <= '0;
    end else begin
      adj_sync <= {adj_sync[0], sw_adj};
      sel_sync <= {sel_sync[0], sw_sel};
    end
  assign adj_s = adj_sync[1];
  assign sel_s = sel_sync[1];

  // mode selection follows the new pause value so HALT starts on the same edge paused flips
  always_comb begin
    paused_n = paused ^ pause_press;
    state_n = adj_s ? ADJ : paused_n ? HALT : RUN;
    adj_stay = (state == ADJ) && (state_n == ADJ);
    adj_exit = (state == ADJ) && (state_n != ADJ);
    run_tick = (state == RUN) && (run_cnt == TW'(TICK_DIV - 1));
    adj_tick = (state == ADJ) && (adj_cnt == AW'(ADJ_DIV - 1));
    blink_end = blink_cnt == BW'(BLINK_DIV - 1);
    scan_end = scan_cnt == SW'(SCAN_DIV - 1);
  end

  // mode state and pause flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      paused <= 1'b0;
    end else begin
      state <= state_n;
      paused <= paused_n;
    end

  // run divider holds in HALT so a resume keeps the partial second
  always_ff @(posedge clk or posedge rst)
    if (rst)
      run_cnt <= '0;
    else if (clr_press || adj_exit)
      run_cnt <= '0;
    else if (state == RUN)
      run_cnt <= run_tick ? '0 : run_cnt + 1'b1;

  // adjust divider and blink phase live only while in ADJ
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      adj_cnt <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      adj_cnt <= (adj_stay && !adj_tick) ? adj_cnt + 1'b1 : '0;
      blink_cnt <= (adj_stay && !blink_end) ? blink_cnt + 1'b1 : '0;
      blink_phase <= adj_stay & (blink_phase ^ blink_end);
    end

  // free-running digit scan
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_end ? '0 : scan_cnt + 1'b1;
      scan_idx <= scan_idx + {1'b0, scan_end};
    end

  assign clr = clr_press;
  assign inc_sec = ~clr_press & (run_tick | (adj_tick & ~sel_s));
  assign inc_min = ~clr_press & adj_tick & sel_s;
  assign mode = state;
  assign blank_min = (state == ADJ) & sel_s & blink_phase;
  assign blank_sec = (state == ADJ) & ~sel_s & blink_phase;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random stimulus checked against a behavioural stopwatch model
module tb_stopwatch_ctrl;
  localparam int TICK = 10, ADJ = 5, BLINK = 3, SCAN = 2, DB = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic btn_pause = 1'b0, btn_clr = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic inc_sec, inc_min, clr, paused, blank_min, blank_sec;
  logic [1:0] mode, scan_idx;
  int n_cmp = 0, n_bad = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK), .ADJ_DIV(ADJ), .BLINK_DIV(BLINK), .SCAN_DIV(SCAN), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_clr(btn_clr), .sw_adj(sw_adj), .sw_sel(sw_sel),
    .inc_sec(inc_sec), .inc_min(inc_min), .clr(clr), .paused(paused), .mode(mode),
    .blank_min(blank_min), .blank_sec(blank_sec), .scan_idx(scan_idx));

  always #5 clk = ~clk;

  // model state: t = cycles since reset release, run_acc = RUN time into the current second,
  // adj_el = cycles spent in ADJ since entry, lvl = accepted button levels
  int t, m_mode, run_acc, adj_el;
  bit m_paused;
  bit d1[4], d2[4];
  bit lvl[2], lvl_prev[2];
  bit q0[$], q1[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  // a button level is accepted once the last DB synced samples all disagree with the current level
  function automatic bit next_level(input bit q[$], input bit cur);
    if (q.size() < DB) return cur;
    foreach (q[i]) if (q[i] == cur) return cur;
    return ~cur;
  endfunction

  task automatic model_reset();
    t = 0; m_mode = 0; run_acc = 0; adj_el = 0; m_paused = 0;
    for (int i = 0; i < 4; i++) begin d1[i] = 0; d2[i] = 0; end
    for (int i = 0; i < 2; i++) begin lvl[i] = 0; lvl_prev[i] = 0; end
    q0.delete(); q1.delete();
  endtask

  // compare every cycle against the model, then advance the model
  always @(negedge clk) begin
    bit pp, cp, sel, tr, ta, paused_n;
    int mode_n;
    if (rst) model_reset();
    else begin
      pp = lvl[0] & ~lvl_prev[0];
      cp = lvl[1] & ~lvl_prev[1];
      sel = d2[3];
      tr = (m_mode == 0) && (run_acc == TICK - 1);
      ta = (m_mode == 2) && (adj_el % ADJ == ADJ - 1);
      chk("inc_sec", inc_sec, !cp && (tr || (ta && !sel)));
      chk("inc_min", inc_min, !cp && ta && sel);
      chk("clr", clr, cp);
      chk("paused", paused, m_paused);
      chk("mode", mode, m_mode);
      chk("blank_min", blank_min, (m_mode == 2) && sel && ((adj_el / BLINK) % 2 == 1));
      chk("blank_sec", blank_sec, (m_mode == 2) && !sel && ((adj_el / BLINK) % 2 == 1));
      chk("scan_idx", scan_idx, (t / SCAN) % 4);
      paused_n = m_paused ^ pp;
      mode_n = d2[2] ? 2 : paused_n ? 1 : 0;
      if (cp || (m_mode == 2 && mode_n != 2)) run_acc = 0;
      else if (m_mode == 0) run_acc = (run_acc + 1) % TICK;
      adj_el = (m_mode == 2 && mode_n == 2) ? adj_el + 1 : 0;
      m_paused = paused_n;
      m_mode = mode_n;
      q0.push_back(d2[0]); if (q0.size() > DB) void'(q0.pop_front());
      q1.push_back(d2[1]); if (q1.size() > DB) void'(q1.pop_front());
      lvl_prev = lvl;
      lvl[0] = next_level(q0, lvl[0]);
      lvl[1] = next_level(q1, lvl[1]);
      d2 = d1;
      d1[0] = btn_pause; d1[1] = btn_clr; d1[2] = sw_adj; d1[3] = sw_sel;
      t++;
    end
  end

  task automatic to_cycle(input int n);
    do begin @(posedge clk); #2; end while (t < n);
  endtask

  task automatic at_neg(input int n);
    to_cycle(n);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_mode", mode, 0); chk("rst_paused", paused, 0); chk("rst_scan", scan_idx, 0);
    at_neg(7); chk("scan_wrap3", scan_idx, 3);
    at_neg(8); chk("scan_wrap0", scan_idx, 0); chk("pre_tick", inc_sec, 0);
    at_neg(9); chk("first_tick", inc_sec, 1);
    to_cycle(13); btn_pause = 1'b1;
    at_neg(19); chk("tick19", inc_sec, 1); chk("pause_pending", paused, 0);
    at_neg(20); chk("paused_set", paused, 1); chk("mode_halt", mode, 1);
    to_cycle(22); btn_pause = 1'b0;
    to_cycle(30); btn_pause = 1'b1;
    at_neg(37); chk("resume_mode", mode, 0); chk("resume_paused", paused, 0);
    to_cycle(38); btn_pause = 1'b0;
    at_neg(45); chk("resume_pre", inc_sec, 0);
    at_neg(46); chk("resume_tick", inc_sec, 1);
    to_cycle(50); btn_pause = 1'b1;
    to_cycle(52); btn_pause = 1'b0;
    to_cycle(54); btn_pause = 1'b1;
    to_cycle(56); btn_pause = 1'b0;
    at_neg(62); chk("bounce_ignored", paused, 0);
    to_cycle(64); sw_adj = 1'b1; sw_sel = 1'b1;
    at_neg(66); chk("adj_latency", mode, 0);
    at_neg(67); chk("adj_mode", mode, 2);
    at_neg(70); chk("blank_min_on", blank_min, 1); chk("blank_sec_off", blank_sec, 0);
    at_neg(71); chk("adj_inc_min", inc_min, 1); chk("adj_no_sec", inc_sec, 0);
    to_cycle(80); sw_sel = 1'b0;
    at_neg(86); chk("adj_inc_sec", inc_sec, 1); chk("adj_no_min", inc_min, 0);
    at_neg(88); chk("blank_sec_on", blank_sec, 1); chk("blank_min_off", blank_min, 0);
    to_cycle(95); sw_adj = 1'b0;
    at_neg(98); chk("adj_exit", mode, 0);
    at_neg(107); chk("exit_tick", inc_sec, 1);
    to_cycle(121); btn_clr = 1'b1;
    to_cycle(126); btn_clr = 1'b0;
    at_neg(127); chk("clr_pulse", clr, 1); chk("clr_wins", inc_sec, 0);
    at_neg(128); chk("clr_once", clr, 0);
    at_neg(136); chk("clr_pre", inc_sec, 0);
    at_neg(137); chk("clr_next_tick", inc_sec, 1);
    to_cycle(140); sw_adj = 1'b1; sw_sel = 1'b1; btn_pause = 1'b1;
    to_cycle(148); btn_pause = 1'b0;
    at_neg(152); chk("g_mode", mode, 2); chk("g_paused", paused, 1); chk("g_blank", blank_min, 1);
    #2 rst = 1'b1;
    sw_adj = 1'b0; sw_sel = 1'b0;
    #1;
    chk("ar_mode", mode, 0); chk("ar_paused", paused, 0); chk("ar_blank", blank_min, 0);
    chk("ar_inc_sec", inc_sec, 0); chk("ar_inc_min", inc_min, 0); chk("ar_clr", clr, 0);
    chk("ar_scan", scan_idx, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rel_paused", paused, 0); chk("rel_mode", mode, 0); chk("rel_strobe", inc_sec, 0);
    at_neg(8); chk("rel_pre", inc_sec, 0);
    at_neg(9); chk("rel_tick", inc_sec, 1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (i == 1500) begin
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
      end
      if ($urandom_range(7) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(8) == 0) btn_clr = ~btn_clr;
      if ($urandom_range(59) == 0) sw_adj = ~sw_adj;
      if ($urandom_range(19) == 0) sw_sel = ~sw_sel;
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
